// File: rtl/bridge_pkg.sv
// bridge_pkg: shared UART state encoding and
// 8N1 frame constants for the SPI-to-UART bridge.
package bridge_pkg;
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int SPI_BYTE_W = 8;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer with baud counter.
// Loads a byte through a valid/ready port.
module uart_tx
  import bridge_pkg::*;
#(
  parameter int CLK_PER_BAUD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  input  logic [DATA_BITS-1:0] load_data,
  output logic                 load_ready,
  output logic                 tx,
  output logic                 tx_busy
);
  localparam int CW =
    (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST =
    CW'(CLK_PER_BAUD - 1);
  localparam logic [IW-1:0] DATA_LAST =
    IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST =
    IW'(STOP_BITS - 1);

  tx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 baud_done;

  assign baud_done = (cnt == BAUD_LAST);

  // state, baud counter, bit index and data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  // next state, counter reloads and line level
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CW'(1);
    idx_n      = idx;
    shift_n    = shift;
    load_ready = 1'b0;
    tx         = 1'b1;
    tx_busy    = 1'b1;
    unique case (state)
      TX_IDLE: begin
        cnt_n      = '0;
        tx_busy    = 1'b0;
        load_ready = 1'b1;
        if (load_valid) begin
          shift_n = load_data;
          idx_n   = '0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (baud_done) begin
          cnt_n   = '0;
          state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        tx = shift[idx];
        if (baud_done) begin
          cnt_n = '0;
          if (idx == DATA_LAST) begin
            idx_n   = '0;
            state_n = TX_STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          cnt_n = '0;
          if (idx == STOP_LAST) begin
            idx_n   = '0;
            state_n = TX_IDLE;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end
endmodule

// File: rtl/spi_to_uart_bridge.sv
// spi_to_uart_bridge: SPI mode-0 write slave feeding
// a byte FIFO that drains onto an 8N1 UART TX line.
module spi_to_uart_bridge
  import bridge_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int CLK_PER_BAUD = CLK_FREQ / BAUD_RATE,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_sclk,
  input  logic            spi_cs_n,
  input  logic            spi_mosi,
  output logic            tx,
  output logic            tx_busy,
  output logic            byte_rx,
  output logic            overflow,
  output logic [ADDR_W:0] fifo_level
);
  localparam int BW = $clog2(SPI_BYTE_W);

  logic [1:0]            sclk_s, cs_s, mosi_s;
  logic                  sclk_d;
  logic                  sclk_rise;
  logic [SPI_BYTE_W-1:0] shift_reg;
  logic [BW-1:0]         bit_cnt;
  logic [SPI_BYTE_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic                  full, push_ok, pop;
  logic                  load_valid, load_ready;
  logic [SPI_BYTE_W-1:0] load_data;

  // 2-FF synchronizers plus sclk history bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= 2'b00;
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
      sclk_d <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], spi_sclk};
      cs_s   <= {cs_s[0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
      sclk_d <= sclk_s[1];
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_d;

  // MSB-first shifter; pulse byte_rx after 8th edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      byte_rx   <= 1'b0;
    end else begin
      byte_rx <= 1'b0;
      if (cs_s[1]) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_reg <= {shift_reg[SPI_BYTE_W-2:0], mosi_s[1]};
        bit_cnt   <= bit_cnt + BW'(1);
        byte_rx   <= (bit_cnt == BW'(SPI_BYTE_W - 1));
      end
    end
  end

  assign full       = (fifo_level == (ADDR_W+1)'(FIFO_DEPTH));
  assign load_valid = (fifo_level != '0);
  assign pop        = load_valid & load_ready;
  assign push_ok    = byte_rx & (~full | pop);
  assign overflow   = byte_rx & full & ~pop;
  assign load_data  = mem[rd_ptr];

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift_reg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push_ok && !pop)
        fifo_level <= fifo_level + (ADDR_W+1)'(1);
      else if (!push_ok && pop)
        fifo_level <= fifo_level - (ADDR_W+1)'(1);
    end
  end

  uart_tx #(
    .CLK_PER_BAUD(CLK_PER_BAUD)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );
endmodule

// File: tb/tb_spi_to_uart_bridge.sv
// tb_spi_to_uart_bridge: directed vectors for the
// SPI-to-UART bridge with a UART frame monitor.
module tb_spi_to_uart_bridge;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic tx, tx_busy, byte_rx, overflow;
  logic [AW:0] fifo_level;

  always #5 clk = ~clk;

  spi_to_uart_bridge #(
    .CLK_PER_BAUD(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .byte_rx   (byte_rx),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  typedef struct {
    logic [7:0] data;
    int         half;
    logic [9:0] frame;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  int rx_cnt = 0, ovf_cnt = 0, ovf_idx = 0;
  int busy_run = 0, last_busy_len = 0;
  int idle_run = 0, last_idle_len = 0;
  int tx_low_cnt = 0, max_level = 0;
  int cyc_n = 0, busy_rise_cyc = 0;
  int lvl_stage = 0, lvl_a = -1, lvl_b = -1;
  bit mon_act = 0;
  int mon_cnt = 0;
  logic [9:0] mon_frame = '0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(
    input logic [7:0] b);
    return {1'b0, b[0], b[1], b[2], b[3],
            b[4], b[5], b[6], b[7], 1'b1};
  endfunction

  // line monitor sampled on the falling clock edge
  initial begin
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst_n) begin
        mon_act   = 0;
        busy_run  = 0;
        lvl_stage = 0;
      end else begin
        if (lvl_stage == 2) begin
          lvl_b = int'(fifo_level);
          lvl_stage = 0;
        end else if (lvl_stage == 1) begin
          lvl_a = int'(fifo_level);
          lvl_stage = 2;
        end
        if (byte_rx) begin
          rx_cnt++;
          lvl_stage = 1;
          if (overflow) begin
            ovf_cnt++;
            ovf_idx = rx_cnt;
          end
        end
        if (int'(fifo_level) > max_level)
          max_level = int'(fifo_level);
        if (tx_busy) begin
          if (busy_run == 0) begin
            busy_rise_cyc = cyc_n;
            last_idle_len = idle_run;
          end
          busy_run++;
          idle_run = 0;
        end else begin
          if (busy_run > 0) last_busy_len = busy_run;
          busy_run = 0;
          idle_run++;
        end
        if (!tx) tx_low_cnt++;
        if (!mon_act && !tx) begin
          mon_act   = 1;
          mon_cnt   = 0;
          mon_frame = '0;
        end
        if (mon_act) begin
          if (mon_cnt % CPB == CPB / 2)
            mon_frame = {mon_frame[8:0], tx};
          if (mon_cnt == CPB / 2 + 9 * CPB) begin
            got_q.push_back(mon_frame);
            mon_act = 0;
          end
          mon_cnt++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b,
                          input int nbits,
                          input int half);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      cyc(half);
      spi_sclk = 1'b1;
      cyc(half);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    cyc(4);
  endtask

  task automatic cs_hi();
    cyc(4);
    spi_cs_n = 1'b1;
    cyc(4);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((tx_busy || fifo_level != 0 || mon_act)
           && k < 5000) begin
      cyc(1);
      k++;
    end
    if (k >= 5000)
      chk({name, "_timeout"}, 32'(k), 32'd0);
    cyc(4);
  endtask

  task automatic chk_frames(input string name);
    chk({name, "_nframes"}, 32'(got_q.size()),
        32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        chk($sformatf("%s_frame%0d", name, i),
            32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[5];
    int rx0, ovf0, low0, k;

    tbl[0] = '{8'hA5, 5, 10'b0101001011};
    tbl[1] = '{8'h00, 4, 10'b0000000001};
    tbl[2] = '{8'hFF, 5, 10'b0111111111};
    tbl[3] = '{8'h5A, 4, 10'b0010110101};
    tbl[4] = '{8'h81, 6, 10'b0100000011};

    cyc(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_byte_rx", 32'(byte_rx), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    cyc(5);

    for (int v = 0; v < 5; v++) begin
      rx0 = rx_cnt;
      ovf0 = ovf_cnt;
      lvl_a = -1;
      lvl_b = -1;
      cs_lo();
      spi_bits(tbl[v].data, 8, tbl[v].half);
      cs_hi();
      wait_idle($sformatf("v%0d", v));
      chk($sformatf("v%0d_byte_rx", v),
          32'(rx_cnt - rx0), 32'd1);
      chk($sformatf("v%0d_ovf", v),
          32'(ovf_cnt - ovf0), 32'd0);
      chk($sformatf("v%0d_lvl_push", v),
          32'(lvl_a), 32'd1);
      chk($sformatf("v%0d_lvl_pop", v),
          32'(lvl_b), 32'd0);
      chk($sformatf("v%0d_busy_len", v),
          32'(last_busy_len), 32'd160);
      exp_q.push_back(tbl[v].frame);
      chk_frames($sformatf("v%0d", v));
    end

    rx0 = rx_cnt;
    max_level = 0;
    cs_lo();
    for (int i = 1; i <= 3; i++)
      spi_bits(8'(i), 8, 5);
    cs_hi();
    wait_idle("burst");
    chk("burst_byte_rx", 32'(rx_cnt - rx0), 32'd3);
    chk("burst_peak", 32'(max_level), 32'd2);
    chk("burst_gap", 32'(last_idle_len), 32'd1);
    for (int i = 1; i <= 3; i++)
      exp_q.push_back(frame_of(8'(i)));
    chk_frames("burst");

    rx0 = rx_cnt;
    ovf0 = ovf_cnt;
    max_level = 0;
    cs_lo();
    for (int i = 0; i < 8; i++)
      spi_bits(8'h10 + 8'(i), 8, 4);
    cs_hi();
    wait_idle("ovf");
    chk("ovf_byte_rx", 32'(rx_cnt - rx0), 32'd8);
    chk("ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);
    chk("ovf_which", 32'(ovf_idx - rx0), 32'd8);
    chk("ovf_peak", 32'(max_level), 32'(DEPTH));
    for (int i = 0; i < 7; i++)
      exp_q.push_back(frame_of(8'h10 + 8'(i)));
    chk_frames("ovf");

    rx0 = rx_cnt;
    cs_lo();
    spi_bits(8'hA0, 5, 5);
    cs_hi();
    cs_lo();
    spi_bits(8'h3C, 8, 5);
    cs_hi();
    wait_idle("abort");
    chk("abort_byte_rx", 32'(rx_cnt - rx0), 32'd1);
    exp_q.push_back(10'b0001111001);
    chk_frames("abort");

    cs_lo();
    spi_bits(8'hFF, 8, 5);
    cs_hi();
    k = 0;
    while (!(tx_busy &&
             cyc_n - busy_rise_cyc >= 4 * CPB + CPB / 2)
           && k < 500) begin
      cyc(1);
      k++;
    end
    chk("mid_timeout", 32'(k >= 500), 32'd0);
    chk("mid_busy", 32'(tx_busy), 32'd1);
    chk("mid_tx", 32'(tx), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    low0 = tx_low_cnt;
    got_q.delete();
    cyc(400);
    chk("post_rst_frames", 32'(got_q.size()), 32'd0);
    chk("post_rst_tx_low", 32'(tx_low_cnt - low0), 32'd0);

    rx0 = rx_cnt;
    low0 = tx_low_cnt;
    spi_cs_n = 1'b1;
    spi_bits(8'hFF, 8, 5);
    cyc(200);
    chk("cs_hi_byte_rx", 32'(rx_cnt - rx0), 32'd0);
    chk("cs_hi_tx_low", 32'(tx_low_cnt - low0), 32'd0);
    chk("cs_hi_frames", 32'(got_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
